// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer: walks S1..S5 per instruction, with a priming
// slot, memory-stall handling with timeout, halt handling and a retired count.
module stage_sequencer #(
  parameter logic [3:0]  NOP_OPCODE  = 4'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned WAIT_LIMIT  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic                   Resume,
  input  logic                   Halt_Req,
  input  logic                   Mem_Busy,
  input  logic [3:0]             IR_Opcode,
  output logic [2:0]             Stage,
  output logic                   NOP_FLAG,
  output logic                   Stall,
  output logic                   Halted,
  output logic                   Timeout,
  output logic [COUNT_WIDTH-1:0] Instr_Count
);

  localparam int unsigned STALL_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_HALTED
  } state_t;

  state_t                 state_q, state_d;
  logic                   prime_q, prime_d;
  logic                   nop_q, nop_d;
  logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   retire;

  // State and bookkeeping registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      prime_q     <= 1'b0;
      nop_q       <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      prime_q     <= prime_d;
      nop_q       <= nop_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
    end
  end

  // Next-state, bookkeeping updates and decoded outputs
  always_comb begin
    state_d     = state_q;
    prime_d     = prime_q;
    nop_d       = nop_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    count_d     = count_q;
    retire      = 1'b0;
    Stage       = 3'd0;
    NOP_FLAG    = 1'b0;
    Stall       = 1'b0;
    Halted      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d = ST_S5;
          prime_d = 1'b1;
        end
      end
      ST_S1: begin
        Stage    = 3'd1;
        NOP_FLAG = (IR_Opcode == NOP_OPCODE);
        if (IR_Opcode == HALT_OPCODE) begin
          state_d = ST_HALTED;
          retire  = 1'b1;
        end else begin
          state_d = ST_S2;
          nop_d   = (IR_Opcode == NOP_OPCODE);
        end
      end
      ST_S2: begin
        Stage    = 3'd2;
        NOP_FLAG = nop_q;
        state_d  = ST_S3;
      end
      ST_S3: begin
        Stage       = 3'd3;
        NOP_FLAG    = nop_q;
        state_d     = ST_S4;
        stall_cnt_d = '0;
      end
      ST_S4: begin
        Stage    = 3'd4;
        NOP_FLAG = nop_q;
        Stall    = Mem_Busy;
        if (Mem_Busy) begin
          // Give up once the full wait budget has already been spent
          if (stall_cnt_q == STALL_W'(WAIT_LIMIT)) begin
            state_d   = ST_HALTED;
            timeout_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end else begin
          state_d = ST_S5;
        end
      end
      ST_S5: begin
        Stage    = 3'd5;
        NOP_FLAG = prime_q | nop_q;
        prime_d  = 1'b0;
        retire   = ~prime_q;
        if (Halt_Req)  state_d = ST_HALTED;
        else if (!Run) state_d = ST_IDLE;
        else           state_d = ST_S1;
      end
      ST_HALTED: begin
        Halted = 1'b1;
        if (Resume && !Halt_Req && !timeout_q) begin
          state_d = ST_S5;
          prime_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturating retired-instruction count
    if (retire && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  assign Timeout     = timeout_q;
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: the driver walks instruction-level scenarios, pushing the
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_stage_sequencer;

  localparam int CW   = 4;
  localparam int WL   = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_PRIME = 1;
  localparam int P_S1    = 2;
  localparam int P_HALT  = 3;

  typedef struct packed {
    logic [2:0]    stage;
    logic          nop;
    logic          stall;
    logic          halted;
    logic          timeout;
    logic [CW-1:0] count;
  } obs_t;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0, Resume = 1'b0, Halt_Req = 1'b0, Mem_Busy = 1'b0;
  logic [3:0]    IR_Opcode = 4'h0;
  logic [2:0]    Stage;
  logic          NOP_FLAG, Stall, Halted, Timeout;
  logic [CW-1:0] Instr_Count;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_count = 0;
  bit   m_timeout = 1'b0;
  int   where = P_IDLE;

  stage_sequencer #(
    .NOP_OPCODE (4'h0),
    .HALT_OPCODE(4'hF),
    .WAIT_LIMIT (WL),
    .COUNT_WIDTH(CW)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
    .Resume     (Resume),
    .Halt_Req   (Halt_Req),
    .Mem_Busy   (Mem_Busy),
    .IR_Opcode  (IR_Opcode),
    .Stage      (Stage),
    .NOP_FLAG   (NOP_FLAG),
    .Stall      (Stall),
    .Halted     (Halted),
    .Timeout    (Timeout),
    .Instr_Count(Instr_Count)
  );

  always #5 Clock = ~Clock;

  // Monitor: compare DUT outputs against the next expected observation
  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {Stage, NOP_FLAG, Stall, Halted, Timeout, Instr_Count};
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL obs @%0t: got stage=%0d nop=%0b stall=%0b halted=%0b timeout=%0b count=%0d, expected stage=%0d nop=%0b stall=%0b halted=%0b timeout=%0b count=%0d",
                    $time, mon_act.stage, mon_act.nop, mon_act.stall, mon_act.halted, mon_act.timeout, mon_act.count,
                    mon_exp.stage, mon_exp.nop, mon_exp.stall, mon_exp.halted, mon_exp.timeout, mon_exp.count);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic bump();
    if (m_count < CMAX) m_count++;
  endtask

  // One clock cycle: drive inputs and queue what the outputs must show this cycle
  task automatic step(input logic run, input logic resume, input logic hr, input logic busy,
                      input logic [3:0] op, input logic [2:0] e_stage, input logic e_nop,
                      input logic e_stall, input logic e_halted);
    obs_t e;
    @(posedge Clock);
    #2;
    Run = run; Resume = resume; Halt_Req = hr; Mem_Busy = busy; IR_Opcode = op;
    e.stage = e_stage; e.nop = e_nop; e.stall = e_stall; e.halted = e_halted;
    e.timeout = m_timeout; e.count = CW'(m_count);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input bit chk_prev, input logic [2:0] prev_stage, input logic run_after);
    @(posedge Clock);
    #1;
    if (chk_prev) check("pre_reset_stage", int'(Stage), int'(prev_stage));
    #1 Reset = 1'b1;
    #1;
    check("rst_stage", int'(Stage), 0);
    check("rst_nop", int'(NOP_FLAG), 0);
    check("rst_stall", int'(Stall), 0);
    check("rst_halted", int'(Halted), 0);
    check("rst_timeout", int'(Timeout), 0);
    check("rst_count", int'(Instr_Count), 0);
    m_count = 0;
    m_timeout = 1'b0;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    Run = run_after; Resume = rb(); Halt_Req = rb(); Mem_Busy = rb(); IR_Opcode = 4'($urandom);
    exp_q.push_back('0);
    where = run_after ? P_PRIME : P_IDLE;
  endtask

  task automatic idle_step(input logic run);
    step(run, rb(), rb(), rb(), 4'($urandom), 3'd0, 1'b0, 1'b0, 1'b0);
    where = run ? P_PRIME : P_IDLE;
  endtask

  task automatic prime_step(input logic hr, input logic run);
    step(run, rb(), hr, rb(), 4'($urandom), 3'd5, 1'b1, 1'b0, 1'b0);
    where = hr ? P_HALT : (run ? P_S1 : P_IDLE);
  endtask

  task automatic halt_step(input logic resume, input logic hr);
    step(rb(), resume, hr, rb(), 4'($urandom), 3'd0, 1'b0, 1'b0, 1'b1);
    if (resume && !hr && !m_timeout) where = P_PRIME;
  endtask

  // One instruction from S1: n_busy memory-wait cycles in S4, S5 exit inputs, optional reset in S3
  task automatic instr(input logic [3:0] op, input int n_busy, input logic hr_exit,
                       input logic run_exit, input bit rst_s3);
    logic nop;
    nop = (op == 4'h0);
    step(rb(), rb(), rb(), rb(), op, 3'd1, nop, 1'b0, 1'b0);
    if (op == 4'hF) begin
      bump();
      where = P_HALT;
      return;
    end
    step(rb(), rb(), rb(), rb(), 4'($urandom), 3'd2, nop, 1'b0, 1'b0);
    if (rst_s3) begin
      apply_reset(1'b1, 3'd3, rb());
      return;
    end
    step(rb(), rb(), rb(), rb(), 4'($urandom), 3'd3, nop, 1'b0, 1'b0);
    for (int i = 0; i < n_busy && i <= WL; i++)
      step(rb(), rb(), rb(), 1'b1, 4'($urandom), 3'd4, nop, 1'b1, 1'b0);
    if (n_busy > WL) begin
      m_timeout = 1'b1;
      where = P_HALT;
      return;
    end
    step(rb(), rb(), rb(), 1'b0, 4'($urandom), 3'd4, nop, 1'b0, 1'b0);
    step(run_exit, rb(), hr_exit, rb(), 4'($urandom), 3'd5, nop, 1'b0, 1'b0);
    bump();
    where = hr_exit ? P_HALT : (run_exit ? P_S1 : P_IDLE);
  endtask

  initial begin
    // Directed scenarios
    apply_reset(1'b0, 3'd0, 1'b1);
    prime_step(1'b0, 1'b1);
    instr(4'h3, 0, 1'b0, 1'b1, 1'b0);
    instr(4'h0, 0, 1'b0, 1'b1, 1'b0);
    instr(4'h5, 3, 1'b0, 1'b1, 1'b0);
    instr(4'h7, 0, 1'b1, 1'b1, 1'b0);
    halt_step(1'b0, 1'b0);
    halt_step(1'b1, 1'b1);
    halt_step(1'b1, 1'b0);
    prime_step(1'b0, 1'b1);
    instr(4'hF, 0, 1'b0, 1'b1, 1'b0);
    halt_step(1'b1, 1'b0);
    prime_step(1'b0, 1'b1);
    instr(4'h2, 12, 1'b0, 1'b1, 1'b0);
    halt_step(1'b1, 1'b0);
    halt_step(1'b1, 1'b0);
    halt_step(1'b1, 1'b0);
    apply_reset(1'b0, 3'd0, 1'b1);
    prime_step(1'b0, 1'b1);
    for (int k = 0; k < CMAX + 3; k++)
      instr(4'($urandom_range(0, 14)), $urandom_range(0, 2), 1'b0, 1'b1, 1'b0);
    instr(4'h4, 0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      case (where)
        P_IDLE:  idle_step($urandom_range(0, 3) != 0);
        P_PRIME: prime_step($urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0);
        P_S1:    instr(4'($urandom),
                       ($urandom_range(0, 15) == 0) ? $urandom_range(WL + 1, WL + 4) : $urandom_range(0, 3),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 19) == 0);
        default: begin
          if (m_timeout) begin
            halt_step(1'b1, 1'b0);
            apply_reset(1'b0, 3'd0, rb());
          end else begin
            halt_step(rb(), $urandom_range(0, 3) == 0);
          end
        end
      endcase
    end

    @(posedge Clock);
    @(negedge Clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
